// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction-fetch sequencer with init, redirect, halt and a one-entry output register
module fetch_ctrl #(
    parameter int                ADDR_W      = 4,
    parameter int                DATA_W      = 8,
    parameter logic [DATA_W-1:0] HALT_CODE   = 8'hFF,
    parameter int                INIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_rst,
    output logic [ADDR_W-1:0] mem_address,
    input  logic [DATA_W-1:0] mem_instruction,
    input  logic              run,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic [DATA_W-1:0] ir,
    output logic [ADDR_W-1:0] ir_pc,
    output logic              ir_valid,
    input  logic              ir_ready,
    output logic              halted
);

    localparam logic [1:0] ST_INIT  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_HALT  = 2'd2;

    localparam int              CNT_W     = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_CYCLES - 1);

    logic [1:0]        state;
    logic [CNT_W-1:0]  init_cnt;
    logic [ADDR_W-1:0] pc;
    logic              capture;
    logic              accept;

    // Capture only when the output register is empty or being drained this edge.
    assign capture = (state == ST_FETCH) && run && !redirect && (!ir_valid || ir_ready);
    assign accept  = ir_valid && ir_ready;

    // Memory-side outputs come straight from registers so no input can ripple into them.
    assign mem_rst     = (state == ST_INIT);
    assign mem_address = pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_INIT;
            init_cnt <= '0;
            pc       <= '0;
            ir       <= '0;
            ir_pc    <= '0;
            ir_valid <= 1'b0;
            halted   <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    if (init_cnt == INIT_LAST) begin
                        state    <= ST_FETCH;
                        init_cnt <= '0;
                    end else begin
                        init_cnt <= init_cnt + CNT_W'(1);
                    end
                end
                ST_FETCH: begin
                    if (redirect) begin
                        // A flush wins over a same-edge acceptance: the entry is dropped, not delivered.
                        pc       <= redirect_addr;
                        ir_valid <= 1'b0;
                    end else if (capture) begin
                        ir       <= mem_instruction;
                        ir_pc    <= pc;
                        ir_valid <= 1'b1;
                        pc       <= pc + ADDR_W'(1);
                        if (mem_instruction == HALT_CODE) begin
                            state  <= ST_HALT;
                            halted <= 1'b1;
                        end
                    end else if (accept) begin
                        ir_valid <= 1'b0;
                    end
                end
                ST_HALT: begin
                    if (redirect) begin
                        pc       <= redirect_addr;
                        ir_valid <= 1'b0;
                        halted   <= 1'b0;
                        state    <= ST_FETCH;
                    end else if (accept) begin
                        ir_valid <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - scoreboard bench for fetch_ctrl against a 16x8 instruction memory model
module tb_fetch_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       mem_rst;
    logic [3:0] mem_address;
    logic [7:0] mem_instruction;
    logic       run = 1'b1;
    logic       redirect = 1'b0;
    logic [3:0] redirect_addr = 4'd0;
    logic [7:0] ir;
    logic [3:0] ir_pc;
    logic       ir_valid;
    logic       ir_ready = 1'b1;
    logic       halted;

    typedef struct packed {
        logic [7:0] ins;
        logic [3:0] pc;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] image [16];
    logic [7:0] mem   [16];

    fetch_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .mem_rst         (mem_rst),
        .mem_address     (mem_address),
        .mem_instruction (mem_instruction),
        .run             (run),
        .redirect        (redirect),
        .redirect_addr   (redirect_addr),
        .ir              (ir),
        .ir_pc           (ir_pc),
        .ir_valid        (ir_valid),
        .ir_ready        (ir_ready),
        .halted          (halted)
    );

    always #5 clk = ~clk;

    // Memory holds garbage until the load strobe copies the image in.
    always @(posedge clk) begin
        if (mem_rst) begin
            for (int i = 0; i < 16; i++) mem[i] <= image[i];
        end
    end
    assign mem_instruction = mem[mem_address];

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Expected stream from a start address up to and including the halt opcode.
    task automatic push_run(input logic [3:0] start);
        logic [3:0] a;
        exp_t       e;
        a = start;
        for (int n = 0; n < 32; n++) begin
            e.ins = image[a];
            e.pc  = a;
            sb.push_back(e);
            if (image[a] == 8'hFF) break;
            a = a + 4'd1;
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst && ir_valid && ir_ready && !redirect) begin
            if (sb.size() == 0) begin
                check("sb_underflow", sb.size(), 1);
            end else begin
                e = sb.pop_front();
                check("ir", ir, e.ins);
                check("ir_pc", ir_pc, e.pc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_halt(input string tag);
        int n;
        n = 0;
        while (!(halted && !ir_valid) && n < 200) begin
            tick();
            n++;
        end
        check({tag, "_halted"}, halted, 1);
        check({tag, "_idle"}, ir_valid, 0);
        check({tag, "_drain"}, sb.size(), 0);
    endtask

    task automatic pulse_redirect(input logic [3:0] addr);
        redirect      = 1'b1;
        redirect_addr = addr;
        tick();
        redirect = 1'b0;
        check("flush_valid", ir_valid, 0);
        check("flush_halted", halted, 0);
        check("flush_pc", mem_address, addr);
    endtask

    task automatic wait_pc(input logic [3:0] p);
        int n;
        n = 0;
        while (!(ir_valid && ir_pc == p) && n < 200) begin
            tick();
            n++;
        end
        check("wait_pc", ir_pc, p);
    endtask

    task automatic check_init_window();
        @(negedge clk);
        check("init_mem_rst0", mem_rst, 1);
        @(negedge clk);
        check("init_mem_rst1", mem_rst, 1);
        @(negedge clk);
        check("init_mem_rst2", mem_rst, 0);
        check("init_no_valid", ir_valid, 0);
        @(negedge clk);
        check("first_valid", ir_valid, 1);
    endtask

    initial begin
        image = '{8'd0, 8'd2, 8'd4, 8'd16, 8'd32, 8'd64, 8'd128, 8'd255,
                  8'h33, 8'd100, 8'd0, 8'd200, 8'd0, 8'd0, 8'd0, 8'd0};
        for (int i = 0; i < 16; i++) mem[i] = 8'hEE;

        #2 rst = 1'b0;
        #1;
        check("rst_mem_rst", mem_rst, 1);
        check("rst_valid", ir_valid, 0);
        check("rst_halted", halted, 0);
        check("rst_addr", mem_address, 0);
        check("rst_ir", ir, 0);
        tick();
        tick();
        rst = 1'b1;
        push_run(4'd0);
        check_init_window();
        wait_halt("boot");
        check("halt_addr", mem_address, 8);
        tick();
        check("halt_addr_hold", mem_address, 8);

        // Redirect out of halt, wraps 15->0 and runs to the next halt.
        pulse_redirect(4'd9);
        push_run(4'd9);
        wait_halt("redir9");

        pulse_redirect(4'd12);
        push_run(4'd12);
        wait_halt("redir12");

        // Backpressure holds ir, ir_pc and pc.
        ir_ready = 1'b0;
        pulse_redirect(4'd2);
        tick();
        for (int i = 0; i < 3; i++) begin
            check("bp_valid", ir_valid, 1);
            check("bp_ir", ir, 4);
            check("bp_ir_pc", ir_pc, 2);
            check("bp_addr", mem_address, 3);
            tick();
        end
        push_run(4'd2);
        ir_ready = 1'b1;
        wait_halt("bp");

        // Redirect coinciding with acceptance drops the flushed entry.
        pulse_redirect(4'd0);
        sb.push_back('{ins: 8'd0, pc: 4'd0});
        wait_pc(4'd1);
        redirect      = 1'b1;
        redirect_addr = 4'd5;
        tick();
        redirect = 1'b0;
        check("race_flush", ir_valid, 0);
        push_run(4'd5);
        wait_halt("race");

        // run=0 pauses the pc while the pending entry still drains.
        pulse_redirect(4'd0);
        push_run(4'd0);
        wait_pc(4'd1);
        run = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("pause_addr", mem_address, 2);
        end
        check("pause_drained", ir_valid, 0);
        run = 1'b1;
        wait_pc(4'd3);

        // Asynchronous reset mid-stream.
        #1 rst = 1'b0;
        #1;
        check("arst_valid", ir_valid, 0);
        check("arst_halted", halted, 0);
        check("arst_ir", ir, 0);
        check("arst_ir_pc", ir_pc, 0);
        check("arst_addr", mem_address, 0);
        check("arst_mem_rst", mem_rst, 1);
        sb.delete();
        tick();
        rst = 1'b1;
        push_run(4'd0);
        check_init_window();
        wait_halt("reboot");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
